fsm_sequencer: RTL and testbench

Parametrised state sequencer: the next-generation replacement for the fixed 4-state binary / one-hot / reversed-one-hot FSMs. One module covers N states, four output encodings, up/down stepping, wrap or saturate at the ends, and a synchronous index load. It sits wherever a small stepping controller drives downstream select or enable lines. Its registered `out` is a drop-in for the old 4-bit FSM outputs when NUM_STATES=4.

---
 rtl/fsm_sequencer.sv | 101 ++++++++++
 tb/tb_fsm_sequencer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/fsm_sequencer.sv
// Parametrised stepping sequencer: N-state index with up/down stepping, wrap or
// saturate at the ends, synchronous load, and a selectable registered output code.
module fsm_sequencer #(
  parameter  int NUM_STATES = 4,
  parameter  int ENCODING   = 0,
  parameter  int WRAP_MODE  = 1,
  localparam int IDX_W      = (NUM_STATES > 2) ? $clog2(NUM_STATES) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in,
  input  logic                  dir,
  input  logic                  load,
  input  logic [IDX_W-1:0]      load_idx,
  output logic [NUM_STATES-1:0] out,
  output logic [IDX_W-1:0]      idx,
  output logic                  wrap,
  output logic                  load_err
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STATES - 1);

  logic [IDX_W-1:0]      r_idx;
  logic [NUM_STATES-1:0] r_out;
  logic                  r_wrap;
  logic                  r_load_err;

  logic [IDX_W-1:0]      w_cur_idx;
  logic [IDX_W-1:0]      w_next_idx;
  logic                  w_next_wrap;
  logic                  w_next_err;

  // Out-of-range indices are treated as state 0 so the output is always a legal code.
  function automatic logic [NUM_STATES-1:0] encode(input logic [IDX_W-1:0] k_in);
    logic [IDX_W-1:0]      k;
    logic [NUM_STATES-1:0] code;
    k    = (int'(k_in) < NUM_STATES) ? k_in : '0;
    code = '0;
    case (ENCODING)
      1:       code = NUM_STATES'(1) << k;
      2:       code = NUM_STATES'(1) << (LAST_IDX - k);
      3:       code = NUM_STATES'(k ^ (k >> 1));
      default: code = NUM_STATES'(k);
    endcase
    return code;
  endfunction

  always_comb begin
    w_cur_idx   = (int'(r_idx) < NUM_STATES) ? r_idx : '0;
    w_next_idx  = r_idx;
    w_next_wrap = 1'b0;
    w_next_err  = 1'b0;
    if (load) begin
      if (int'(load_idx) < NUM_STATES) begin
        w_next_idx = load_idx;
      end else begin
        w_next_err = 1'b1;
      end
    end else if (in) begin
      if (!dir) begin
        if (w_cur_idx != LAST_IDX) begin
          w_next_idx = w_cur_idx + 1'b1;
        end else if (WRAP_MODE != 0) begin
          w_next_idx  = '0;
          w_next_wrap = 1'b1;
        end else begin
          w_next_idx = w_cur_idx;
        end
      end else begin
        if (w_cur_idx != '0) begin
          w_next_idx = w_cur_idx - 1'b1;
        end else if (WRAP_MODE != 0) begin
          w_next_idx  = LAST_IDX;
          w_next_wrap = 1'b1;
        end else begin
          w_next_idx = w_cur_idx;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx      <= '0;
      r_out      <= encode('0);
      r_wrap     <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_idx      <= w_next_idx;
      r_out      <= encode(w_next_idx);
      r_wrap     <= w_next_wrap;
      r_load_err <= w_next_err;
    end
  end

  assign idx      = r_idx;
  assign out      = r_out;
  assign wrap     = r_wrap;
  assign load_err = r_load_err;

endmodule

// File: tb/tb_fsm_sequencer.sv
// Scoreboard bench: several sequencer configurations share one stimulus stream;
// each has its own reference model, expected-value queue and monitor.
module tb_fsm_sequencer;

  localparam int NCFG = 8;
  localparam int CFG_N   [NCFG] = '{4, 4, 4, 4, 4, 5, 2, 5};
  localparam int CFG_ENC [NCFG] = '{0, 1, 2, 3, 0, 0, 3, 2};
  localparam int CFG_WM  [NCFG] = '{1, 1, 1, 1, 0, 1, 1, 0};

  typedef struct {
    logic [31:0] idx;
    logic [31:0] out;
    logic [31:0] wrap;
    logic [31:0] err;
  } exp_t;

  logic       clk = 1'b0;
  logic       stim_rst = 1'b1;
  logic       stim_in = 1'b0;
  logic       stim_dir = 1'b0;
  logic       stim_load = 1'b0;
  logic [3:0] stim_li = 4'd0;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  always #5 clk = ~clk;

  function automatic int enc_ref(input int n, input int e, input int m);
    case (e)
      1:       return 1 << m;
      2:       return 1 << (n - 1 - m);
      3:       return m ^ (m >> 1);
      default: return m;
    endcase
  endfunction

  task automatic check(input string name, input int cfg, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cfg%0d cycle %0d: got %0h expected %0h", name, cfg, cycle, act, exp);
    end
  endtask

  genvar gi;
  generate
    for (gi = 0; gi < NCFG; gi++) begin : g_cfg
      localparam int N  = CFG_N[gi];
      localparam int IW = (N > 2) ? $clog2(N) : 1;

      logic [IW-1:0] dut_li;
      logic [N-1:0]  dut_out;
      logic [IW-1:0] dut_idx;
      logic          dut_wrap;
      logic          dut_err;
      exp_t          q[$];

      assign dut_li = stim_li[IW-1:0];

      fsm_sequencer #(
        .NUM_STATES(N),
        .ENCODING  (CFG_ENC[gi]),
        .WRAP_MODE (CFG_WM[gi])
      ) u_dut (
        .clk     (clk),
        .reset   (stim_rst),
        .in      (stim_in),
        .dir     (stim_dir),
        .load    (stim_load),
        .load_idx(dut_li),
        .out     (dut_out),
        .idx     (dut_idx),
        .wrap    (dut_wrap),
        .load_err(dut_err)
      );

      // Reference: index arithmetic done modulo N (wrap) or clamped (saturate).
      initial begin
        int   m;
        int   li;
        exp_t x;
        m = 0;
        forever begin
          @(posedge clk);
          li = int'(stim_li) & ((1 << IW) - 1);
          x.wrap = 0;
          x.err  = 0;
          if (stim_rst) begin
            m = 0;
          end else if (stim_load) begin
            if (li < N) m = li;
            else x.err = 1;
          end else if (stim_in) begin
            if (CFG_WM[gi] != 0) begin
              x.wrap = (stim_dir ? (m == 0) : (m == N - 1)) ? 1 : 0;
              m = (m + (stim_dir ? N - 1 : 1)) % N;
            end else begin
              m = stim_dir ? ((m > 0) ? m - 1 : 0) : ((m < N - 1) ? m + 1 : N - 1);
            end
          end
          x.idx = m;
          x.out = enc_ref(N, CFG_ENC[gi], m);
          q.push_back(x);
        end
      end

      initial begin
        exp_t x;
        forever begin
          @(negedge clk);
          if (q.size() > 0) begin
            x = q.pop_front();
            check("idx",      gi, 32'(dut_idx),  x.idx);
            check("out",      gi, 32'(dut_out),  x.out);
            check("wrap",     gi, 32'(dut_wrap), x.wrap);
            check("load_err", gi, 32'(dut_err),  x.err);
          end
        end
      end
    end
  endgenerate

  task automatic cyc(input logic r, input logic ld, input logic [3:0] li,
                     input logic i, input logic d);
    stim_rst  = r;
    stim_load = ld;
    stim_li   = li;
    stim_in   = i;
    stim_dir  = d;
    $display("cycle %0d: reset=%0b load=%0b load_idx=%0d in=%0b dir=%0b",
             cycle, r, ld, li, i, d);
    @(negedge clk);
    cycle++;
  endtask

  initial begin
    @(negedge clk);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    for (int k = 0; k < 8; k++) cyc(0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) cyc(0, 0, 0, 1, 1);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 4'd6, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 4'd4, 1, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    for (int k = 0; k < 6; k++) cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 1);
    cyc(0, 1, 4'd2, 0, 0);
    cyc(1, 1, 4'd1, 1, 0);
    cyc(0, 0, 0, 0, 0);
    for (int k = 0; k < 400; k++) begin
      cyc(($urandom_range(0, 31) == 0), ($urandom_range(0, 7) == 0),
          4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 2) == 0));
    end
    cyc(0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
